// File: rtl/fpmul_seq_pkg.sv
// Shared types and constants for the bfloat16 multiplier sequencer.
package fpmul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GET_B = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [15:0] FP_NAN    = 16'h7FC0;
    localparam int          DEF_WIDTH = 16;

endpackage

// File: rtl/fpmul_seq_timer.sv
// Watchdog counter for the multiplier handshake; expired is high in the
// LIMIT-th consecutive enabled cycle after a clear.
module fpmul_seq_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_r;

    // Count enabled cycles, restarting from zero whenever cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign expired = enable && (cnt_r == CW'(LIMIT - 1));

endmodule

// File: rtl/fpmul_seq_ctrl.sv
// Sequencer between the SPI word interface and the bfloat16 multiplier.
// Optional multiplier watchdog enabled by defining FPMUL_SEQ_TIMEOUT_EN.
module fpmul_seq_ctrl
    import fpmul_seq_pkg::*;
#(
    parameter int          WIDTH          = DEF_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_active,
    input  logic             rx_valid,
    input  logic [WIDTH-1:0] rx_data,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_y,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_load,
    output logic             busy,
    output logic             result_valid,
    output logic             ovr,
    output logic             err
);

    state_t             state_r;
    logic [WIDTH-1:0]   mul_a_r;
    logic [WIDTH-1:0]   mul_b_r;
    logic [WIDTH-1:0]   tx_data_r;
    logic               mul_start_r;
    logic               tx_load_r;
    logic               busy_r;
    logic               result_valid_r;
    logic               ovr_r;
    logic               err_r;
    logic               timeout_s;

`ifdef FPMUL_SEQ_TIMEOUT_EN
    fpmul_seq_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_r != WAIT),
        .enable  (state_r == WAIT),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Frame sequencing FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            mul_a_r        <= '0;
            mul_b_r        <= '0;
            tx_data_r      <= '0;
            mul_start_r    <= 1'b0;
            tx_load_r      <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            ovr_r          <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            mul_start_r <= 1'b0;
            tx_load_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_valid) begin
                        mul_a_r        <= rx_data;
                        result_valid_r <= 1'b0;
                        ovr_r          <= 1'b0;
                        err_r          <= 1'b0;
                        busy_r         <= 1'b1;
                        state_r        <= GET_B;
                    end
                end
                GET_B: begin
                    // A word arriving with the frame end still completes the pair.
                    if (rx_valid) begin
                        mul_b_r     <= rx_data;
                        mul_start_r <= 1'b1;
                        state_r     <= START;
                    end else if (!cs_active) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (rx_valid) begin
                        ovr_r <= 1'b1;
                    end
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (rx_valid) begin
                        ovr_r <= 1'b1;
                    end
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    if (mul_done) begin
                        tx_data_r      <= mul_y;
                        tx_load_r      <= 1'b1;
                        result_valid_r <= 1'b1;
                        busy_r         <= 1'b0;
                        state_r        <= IDLE;
                    end else if (timeout_s) begin
                        tx_data_r      <= WIDTH'(FP_NAN);
                        tx_load_r      <= 1'b1;
                        result_valid_r <= 1'b0;
                        err_r          <= 1'b1;
                        busy_r         <= 1'b0;
                        state_r        <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign mul_start    = mul_start_r;
    assign mul_a        = mul_a_r;
    assign mul_b        = mul_b_r;
    assign tx_data      = tx_data_r;
    assign tx_load      = tx_load_r;
    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign ovr          = ovr_r;
    assign err          = err_r;

endmodule
